// File: rtl/sha256_msg_schedule_if.sv
// Block-load and schedule-word handshake between the SHA-256 message schedule and its neighbours.
// The schedule stage attaches through the slave modport; its driver uses the master modport.
interface sha256_msg_schedule_if;
    logic        start;
    logic        word_valid_i;
    logic [31:0] word_i;
    logic        word_ready_o;
    logic        adv_i;
    logic [31:0] w_o;
    logic        w_valid_o;
    logic [5:0]  t_o;
    logic        last_o;
    logic        done_o;

    modport slave (
        input  start, word_valid_i, word_i, adv_i,
        output word_ready_o, w_o, w_valid_o, t_o, last_o, done_o
    );

    modport master (
        output start, word_valid_i, word_i, adv_i,
        input  word_ready_o, w_o, w_valid_o, t_o, last_o, done_o
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words, then emits W_0..W_63 from a 16-word
// sliding window, one word per advance.
module sha256_msg_schedule (
    input logic                  CLK,
    input logic                  RST,
    sha256_msg_schedule_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

    state_e      state_q;
    logic [31:0] win_q [16];
    logic [3:0]  cnt_q;
    logic [5:0]  t_q;
    logic        done_q;
    logic [31:0] w_next;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Window holds W_t..W_{t+15}; the pushed word is W_{t+16}.
    assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    if (bus.word_valid_i) begin
                        for (int i = 0; i < 15; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[15] <= bus.word_i;
                        cnt_q     <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= StExpand;
                            t_q     <= '0;
                        end
                    end
                end
                StExpand: begin
                    if (bus.adv_i) begin
                        for (int i = 0; i < 15; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[15] <= w_next;
                        t_q       <= t_q + 6'd1;
                        if (t_q == 6'd63) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.word_ready_o = (state_q == StLoad);
    assign bus.w_valid_o    = (state_q == StExpand);
    assign bus.w_o          = (state_q == StExpand) ? win_q[0] : '0;
    assign bus.t_o          = t_q;
    assign bus.last_o       = (state_q == StExpand) && (t_q == 6'd63);
    assign bus.done_o       = done_q;
endmodule
